// File: rtl/reset_sequencer.sv
// Reset sequencer: asserts reset to every domain, waits for all synchronized acks,
// then releases domains in index order. Optional wait timeout: RESET_SEQ_TIMEOUT_EN.
module reset_sequencer #(
    parameter int NUM_DOMAINS     = 4,
    parameter int HOLD_CYCLES     = 8,
    parameter int ACK_SYNC_STAGES = 2,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    output logic [NUM_DOMAINS-1:0] domain_reset,
    input  logic [NUM_DOMAINS-1:0] domain_ack,
    output logic                   all_ready,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam int CNT_MAX = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);

    generate
        if (NUM_DOMAINS < 1) begin : g_bad_domains
            $error("reset_sequencer: NUM_DOMAINS must be >= 1");
        end
        if (HOLD_CYCLES < 1) begin : g_bad_hold
            $error("reset_sequencer: HOLD_CYCLES must be >= 1");
        end
        if (ACK_SYNC_STAGES < 2) begin : g_bad_sync
            $error("reset_sequencer: ACK_SYNC_STAGES must be >= 2");
        end
    endgenerate

    // Acknowledges are asynchronous to clk; only the last sync stage reaches the FSM.
    logic [NUM_DOMAINS-1:0] w_ack_s;

    generate
        for (genvar gi = 0; gi < NUM_DOMAINS; gi++) begin : g_ack_sync
            logic [ACK_SYNC_STAGES-1:0] r_sync;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_sync <= '0;
                end else begin
                    r_sync <= {r_sync[ACK_SYNC_STAGES-2:0], domain_ack[gi]};
                end
            end

            assign w_ack_s[gi] = r_sync[ACK_SYNC_STAGES-1];
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_ASSERT,
        ST_WAIT_ACK,
        ST_RELEASE,
        ST_WAIT_REL,
        ST_READY
    } state_t;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [IDX_W-1:0]       r_idx;
    logic [NUM_DOMAINS-1:0] r_domain_reset;
    logic                   r_all_ready;
    logic                   r_req_ready;
    logic                   r_busy;

    logic                   w_all_ack;
    logic                   w_any_ack;
    logic                   w_cur_ack;
    logic                   w_req_accept;
    logic                   w_wait_expired;
    logic [IDX_W-1:0]       w_idx_next;

    assign w_all_ack    = &w_ack_s;
    assign w_any_ack    = |w_ack_s;
    assign w_cur_ack    = w_ack_s[r_idx];
    assign w_req_accept = req_valid & r_req_ready;
    assign w_idx_next   = r_idx + 1'b1;

`ifdef RESET_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic r_timeout_err;

    assign w_wait_expired = (r_cnt == TIMEOUT_LAST);
    assign timeout_err    = r_timeout_err;
`else
    assign w_wait_expired = 1'b0;
    assign timeout_err    = 1'b0;
`endif

    // Outputs are registered alongside the state so they change on the transition edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_ASSERT;
            r_cnt          <= '0;
            r_idx          <= '0;
            r_domain_reset <= '1;
            r_all_ready    <= 1'b0;
            r_req_ready    <= 1'b0;
            r_busy         <= 1'b1;
`ifdef RESET_SEQ_TIMEOUT_EN
            r_timeout_err  <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_ASSERT: begin
                    if (r_cnt == HOLD_LAST) begin
                        r_state <= ST_WAIT_ACK;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_WAIT_ACK: begin
                    if (w_all_ack || w_wait_expired) begin
                        r_state           <= ST_RELEASE;
                        r_cnt             <= '0;
                        r_idx             <= '0;
                        r_domain_reset[0] <= 1'b0;
`ifdef RESET_SEQ_TIMEOUT_EN
                        if (!w_all_ack) begin
                            r_timeout_err <= 1'b1;
                        end
`endif
                    end else begin
`ifdef RESET_SEQ_TIMEOUT_EN
                        r_cnt <= r_cnt + 1'b1;
`endif
                    end
                end

                ST_RELEASE: begin
                    r_state <= ST_WAIT_REL;
                    r_cnt   <= '0;
                end

                ST_WAIT_REL: begin
                    if (!w_cur_ack || w_wait_expired) begin
                        r_cnt <= '0;
`ifdef RESET_SEQ_TIMEOUT_EN
                        if (w_cur_ack) begin
                            r_timeout_err <= 1'b1;
                        end
`endif
                        if (r_idx == IDX_LAST) begin
                            r_state     <= ST_READY;
                            r_all_ready <= 1'b1;
                            r_req_ready <= 1'b1;
                            r_busy      <= 1'b0;
                        end else begin
                            r_state                    <= ST_RELEASE;
                            r_idx                      <= w_idx_next;
                            r_domain_reset[w_idx_next] <= 1'b0;
                        end
                    end else begin
`ifdef RESET_SEQ_TIMEOUT_EN
                        r_cnt <= r_cnt + 1'b1;
`endif
                    end
                end

                ST_READY: begin
                    // Level check: a domain back in reset is caught even if its ack rose mid-sequence.
                    if (w_req_accept || w_any_ack) begin
                        r_state        <= ST_ASSERT;
                        r_cnt          <= '0;
                        r_idx          <= '0;
                        r_domain_reset <= '1;
                        r_all_ready    <= 1'b0;
                        r_req_ready    <= 1'b0;
                        r_busy         <= 1'b1;
`ifdef RESET_SEQ_TIMEOUT_EN
                        if (w_req_accept) begin
                            r_timeout_err <= 1'b0;
                        end
`endif
                    end
                end

                default: begin
                    r_state        <= ST_ASSERT;
                    r_cnt          <= '0;
                    r_idx          <= '0;
                    r_domain_reset <= '1;
                    r_all_ready    <= 1'b0;
                    r_req_ready    <= 1'b0;
                    r_busy         <= 1'b1;
                end
            endcase
        end
    end

    assign domain_reset = r_domain_reset;
    assign all_ready    = r_all_ready;
    assign req_ready    = r_req_ready;
    assign busy         = r_busy;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: acks modelled as domain_reset delayed 7 cycles; expected
// outputs come from a per-sequence timeline computed arithmetically.
module tb_reset_sequencer;

    localparam int N     = 4;
    localparam int H     = 8;
    localparam int S     = 2;
    localparam int TO    = 16;
    localparam int D     = 7;
    localparam int P     = D + S;
    localparam int NEVER = 1 << 30;

    logic         clk       = 1'b0;
    logic         reset     = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic         all_ready;
    logic         busy;
    logic         timeout_err;
    logic [N-1:0] domain_reset;
    logic [N-1:0] domain_ack = '0;

    always #5 clk = ~clk;

    reset_sequencer #(
        .NUM_DOMAINS    (N),
        .HOLD_CYCLES    (H),
        .ACK_SYNC_STAGES(S),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .domain_reset(domain_reset),
        .domain_ack  (domain_ack),
        .all_ready   (all_ready),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    int           checks   = 0;
    int           failures = 0;
    int           cyc      = 0;
    int           txn      = 0;
    int           seq_s    = 0;
    int           r0       = NEVER;
    bit           exp_terr = 1'b0;
    logic [N-1:0] hist [D];
    logic [N-1:0] ack_hi   = '0;
    logic [N-1:0] ack_lo   = '0;

    task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at cyc %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Timeline: sequence starts at edge seq_s, domain k releases at r0 + k*P, READY at r0 + N*P.
    function automatic logic [N-1:0] exp_dr(int e);
        logic [N-1:0] ones;
        int k;
        ones = '1;
        if (e < seq_s) return '0;
        if (e < r0) return ones;
        k = (e - r0) / P;
        if (k > N - 1) k = N - 1;
        return ones << (k + 1);
    endfunction

    function automatic bit exp_ready(int e);
        if (e < seq_s) return 1'b1;
        return (e >= r0 + N * P);
    endfunction

    task automatic begin_seq(int s, int cstart);
        seq_s = s;
        r0 = (cstart + H + 1 > s + P) ? cstart + H + 1 : s + P;
    endtask

    task automatic update_ack();
        domain_ack = (hist[D-1] | ack_hi) & ~ack_lo;
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        for (int k = D - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = domain_reset;
        update_ack();
    endtask

    task automatic check_cycle();
        check_val("domain_reset", domain_reset, exp_dr(cyc));
        check_val("all_ready", all_ready, exp_ready(cyc));
        check_val("busy", busy, !exp_ready(cyc));
        check_val("req_ready", req_ready, exp_ready(cyc));
        check_val("timeout_err", timeout_err, exp_terr);
    endtask

    task automatic step();
        tick();
        check_cycle();
    endtask

    task automatic run_until(int e);
        while (cyc < e) step();
    endtask

    task automatic finish_seq(string name);
        run_until(r0 + N * P);
        txn++;
        $display("txn %0d %s: first release at cyc %0d, ready at cyc %0d", txn, name, r0, cyc);
    endtask

    task automatic do_reset(int len, bit hold_req);
        reset     = 1'b1;
        req_valid = hold_req;
        exp_terr  = 1'b0;
        begin_seq(cyc + 1, cyc + len);
        repeat (len) step();
        reset = 1'b0;
        finish_seq("reset");
        if (hold_req) begin
            begin_seq(cyc + 1, cyc + 1);
            step();
            req_valid = 1'b0;
            finish_seq("held request");
        end
    endtask

    task automatic start_request(int pulse);
        req_valid = 1'b1;
        exp_terr  = 1'b0;
        begin_seq(cyc + 1, cyc + 1);
        repeat (pulse) step();
        req_valid = 1'b0;
    endtask

    task automatic ack_force(int j, bit with_req);
        int s;
        ack_hi[j] = 1'b1;
        if (with_req) begin
            req_valid = 1'b1;
            exp_terr  = 1'b0;
            s = cyc + 1;
        end else begin
            s = cyc + S + 1;
        end
        update_ack();
        begin_seq(s, s);
        run_until(s);
        ack_hi    = '0;
        req_valid = 1'b0;
        update_ack();
        finish_seq(with_req ? "ack rise with request" : "ack rise");
    endtask

    task automatic wait_rel_reset(int k, int len);
        start_request(1);
        run_until(r0 + k * P + 1 + $urandom_range(0, P - 2));
        do_reset(len, 1'b0);
    endtask

    task automatic stuck_ack(int j);
        int s;
        ack_lo[j] = 1'b1;
        update_ack();
        req_valid = 1'b1;
        exp_terr  = 1'b0;
        s = cyc + 1;
        seq_s = s;
`ifdef RESET_SEQ_TIMEOUT_EN
        r0 = s + H + TO;
        step();
        req_valid = 1'b0;
        run_until(r0 - 1);
        exp_terr = 1'b1;
        step();
        ack_lo = '0;
        update_ack();
`else
        r0 = NEVER;
        step();
        req_valid = 1'b0;
        run_until(s + H + 30 + $urandom_range(0, 20));
        ack_lo = '0;
        update_ack();
        r0 = cyc + S + 1;
`endif
        finish_seq("stuck ack");
    endtask

    initial begin
        int sel;
        for (int k = 0; k < D; k++) hist[k] = '0;

        do_reset(3, 1'b0);
        start_request(1);
        finish_seq("request");
        ack_force(2, 1'b0);
        ack_force(1, 1'b1);
        wait_rel_reset(2, 1);
        stuck_ack(1);
        start_request(2);
        finish_seq("request after stuck");
        do_reset(3, 1'b1);

        for (int t = 0; t < 12; t++) begin
            run_until(cyc + $urandom_range(0, 4));
            sel = $urandom_range(0, 3);
            case (sel)
                0: begin
                    start_request($urandom_range(1, 3));
                    finish_seq("request");
                end
                1: ack_force($urandom_range(0, N - 1), 1'b0);
                2: ack_force($urandom_range(0, N - 1), 1'b1);
                default: wait_rel_reset($urandom_range(0, N - 1), $urandom_range(1, 3));
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
